inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'd0: PC value loaded on reset.
REQ-002 Parameter PC_INC, default 64'd4: sequential PC increment.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  downstream not ready; hold PC and IF/ID register.
REQ-006 branch_taken  input  1  redirect fetch to branch_target; flush IF/ID.
REQ-007 branch_target  input  64  redirect address.
REQ-008 Instruction  input  32  word returned combinationally by Instruction_Memory for Inst_Address.
REQ-009 Inst_Address  output  64  current PC, driven to Instruction_Memory.
REQ-010 if_instruction  output  32  registered instruction to decode/register-file stage.
REQ-011 if_pc  output  64  PC of if_instruction.
REQ-012 if_valid  output  1  if_instruction/if_pc hold a live instruction.
REQ-013 halted  output  1  sticky misaligned-redirect error.
REQ-014 fetch_count  output  32  number of instructions captured since reset, saturating.

Function
REQ-015 Inst_Address SHALL equal the PC register directly (no combinational path from inputs).
REQ-016 FSM states: BOOT, RUN, HALT; reset forces BOOT.
REQ-017 BOOT: no capture, if_valid=0, PC held at RESET_PC; unconditional transition to RUN next cycle; stall and branch_taken ignored.
REQ-018 RUN, priority 1 branch_taken with branch_target[1:0]==0: PC<=branch_target, if_valid<=0, if_instruction/if_pc held, fetch_count unchanged.
REQ-019 RUN, branch_taken with branch_target[1:0]!=0: PC held, if_valid<=0, halted<=1, transition to HALT.
REQ-020 RUN, priority 2 stall (no branch_taken): PC, if_instruction, if_pc, if_valid, fetch_count all held.
REQ-021 RUN, neither: if_instruction<=Instruction, if_pc<=PC, if_valid<=1, PC<=PC+PC_INC, fetch_count+=1.
REQ-022 branch_taken and stall asserted together: branch wins (REQ-018/019).
REQ-023 PC arithmetic SHALL be 64-bit modulo 2^64; PC=64'hFFFF_FFFF_FFFF_FFFC advances to 64'h0.
REQ-024 fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-025 HALT: all registers held, if_valid=0, halted=1; only reset exits.
REQ-026 Latency: instruction at PC appears on if_instruction one cycle after PC is presented, absent stall/branch.

Reset
REQ-027 On reset edge: PC=RESET_PC, state=BOOT, if_instruction=32'h0, if_pc=64'h0, if_valid=0, halted=0, fetch_count=0.
REQ-028 Reset SHALL take priority over all inputs, including mid-stall, mid-redirect and HALT.
REQ-029 First capture occurs on the second rising edge after reset deasserts (one BOOT cycle).

Structure
REQ-030 Shared package SHALL hold FSM state encoding, XLEN=64, ILEN=32 and the default PC_INC.
REQ-031 One sub-module is natural: pc_reg (64-bit PC register with reset value, hold, load); FSM and IF/ID register stay in inst_fetch.

Verification
REQ-032 Reset then run 4 cycles, Instruction tied to per-address values -> Inst_Address 0,0,4,8,12; if_pc 0,4,8 with if_valid=1 from cycle 3; fetch_count=3.
REQ-033 stall high 3 cycles at PC=8 -> Inst_Address stays 8, if_pc stays 4, fetch_count unchanged; resumes with if_pc=8 next cycle.
REQ-034 branch_taken with target 64'h100 while stall=1 -> next cycle Inst_Address=64'h100, if_valid=0; following cycle if_pc=64'h100, if_valid=1.
REQ-035 branch_taken with target 64'h102 -> halted=1, if_valid=0, Inst_Address frozen for 10 cycles; reset -> halted=0, Inst_Address=RESET_PC.
REQ-036 Redirect to 64'hFFFF_FFFF_FFFF_FFFC, run 2 cycles -> if_pc=64'hFFFF_FFFF_FFFF_FFFC, Inst_Address wraps to 64'h0.
REQ-037 Assert reset during a stall at PC=64'h20 -> next edge all outputs at REQ-027 values, one BOOT cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: datapath widths, default PC step and the FSM encoding.
package inst_fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_INC_DEFAULT = 64'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, otherwise load or hold.
module inst_fetch_pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_next_pc,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_next_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, branch redirect, misaligned-redirect halt and IF/ID register.
// state   | meaning
// BOOT    | one idle cycle after reset, PC parked at RESET_PC
// RUN     | fetching; branch beats stall, stall beats sequential capture
// HALT    | misaligned redirect seen; everything frozen until reset
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'd0,
    parameter logic [XLEN-1:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [ILEN-1:0] Instruction,
    output logic [XLEN-1:0] Inst_Address,
    output logic [ILEN-1:0] if_instruction,
    output logic [XLEN-1:0] if_pc,
    output logic            if_valid,
    output logic            halted,
    output logic [31:0]     fetch_count
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic            w_capture;
    logic            w_redirect;
    logic            w_fault;
    logic            w_pc_load;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_next;

    logic [ILEN-1:0] r_if_instruction;
    logic [XLEN-1:0] r_if_pc;
    logic            r_if_valid;
    logic            r_halted;
    logic [31:0]     r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN:  if (branch_taken && !is_word_aligned(branch_target)) w_state_next = ST_HALT;
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        w_capture  = 1'b0;
        w_redirect = 1'b0;
        w_fault    = 1'b0;
        if (r_state == ST_RUN) begin
            if (branch_taken) begin
                if (is_word_aligned(branch_target)) w_redirect = 1'b1;
                else                                 w_fault    = 1'b1;
            end else if (!stall) begin
                w_capture = 1'b1;
            end
        end
    end

    // Sequential step wraps modulo 2^64 through the natural adder overflow.
    assign w_pc_load = w_redirect | w_capture;
    assign w_pc_next = w_redirect ? branch_target : (w_pc + PC_INC);

    inst_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_pc_load),
        .i_next_pc (w_pc_next),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_instruction <= '0;
            r_if_pc          <= '0;
            r_if_valid       <= 1'b0;
            r_halted         <= 1'b0;
            r_fetch_count    <= '0;
        end else if (w_capture) begin
            r_if_instruction <= Instruction;
            r_if_pc          <= w_pc;
            r_if_valid       <= 1'b1;
            if (r_fetch_count != 32'hFFFF_FFFF) r_fetch_count <= r_fetch_count + 32'd1;
        end else if (w_redirect || w_fault) begin
            r_if_valid <= 1'b0;
            if (w_fault) r_halted <= 1'b1;
        end
    end

    assign Inst_Address   = w_pc;
    assign if_instruction = r_if_instruction;
    assign if_pc          = r_if_pc;
    assign if_valid       = r_if_valid;
    assign halted         = r_halted;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random stimulus against a cycle-level behavioural model.
module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the fetch stage
    logic [63:0] m_pc;
    logic        m_booting;
    logic        m_halted;
    logic [31:0] m_ir;
    logic [63:0] m_ipc;
    logic        m_valid;
    logic [31:0] m_cnt;

    inst_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .Instruction    (Instruction),
        .Inst_Address   (Inst_Address),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [63:0] addr);
        return (addr[31:0] * 32'h9E37_79B1) ^ addr[63:32] ^ 32'h00C0_FFEE;
    endfunction

    always_comb Instruction = imem(Inst_Address);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("Inst_Address",   Inst_Address,   m_pc);
        check("if_instruction", if_instruction, m_ir);
        check("if_pc",          if_pc,          m_ipc);
        check("if_valid",       if_valid,       m_valid);
        check("halted",         halted,         m_halted);
        check("fetch_count",    fetch_count,    m_cnt);
    endtask

    // Apply one cycle of inputs, advance the model, then compare just after the edge.
    task automatic step(input logic rst, input logic st, input logic br, input logic [63:0] tgt);
        reset         = rst;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        if (rst) begin
            m_pc = 64'd0; m_booting = 1'b1; m_halted = 1'b0;
            m_ir = 32'd0; m_ipc = 64'd0; m_valid = 1'b0; m_cnt = 32'd0;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (br) begin
            m_valid = 1'b0;
            if (tgt % 4 == 0) m_pc = tgt;
            else              m_halted = 1'b1;
        end else if (!st) begin
            m_ir    = imem(m_pc);
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [63:0] frozen;
        logic [63:0] tgt;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

        // Reset and sequential fetch
        step(1, 0, 0, 64'd0);
        check("rst_addr", Inst_Address, 64'd0);
        check("rst_valid", if_valid, 1'b0);
        step(0, 0, 0, 64'd0);
        check("boot_addr", Inst_Address, 64'd0);
        check("boot_valid", if_valid, 1'b0);
        step(0, 0, 0, 64'd0);
        check("run1_addr", Inst_Address, 64'd4);
        check("run1_ifpc", if_pc, 64'd0);
        check("run1_valid", if_valid, 1'b1);
        check("run1_inst", if_instruction, imem(64'd0));
        step(0, 0, 0, 64'd0);
        check("run2_addr", Inst_Address, 64'd8);
        check("run2_ifpc", if_pc, 64'd4);

        // Stall at PC=8
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 64'd0);
            check("stall_addr", Inst_Address, 64'd8);
            check("stall_ifpc", if_pc, 64'd4);
            check("stall_cnt", fetch_count, 32'd2);
        end
        step(0, 0, 0, 64'd0);
        check("resume_ifpc", if_pc, 64'd8);
        check("resume_cnt", fetch_count, 32'd3);

        // Branch wins over stall
        step(0, 1, 1, 64'h100);
        check("br_addr", Inst_Address, 64'h100);
        check("br_valid", if_valid, 1'b0);
        check("br_cnt", fetch_count, 32'd3);
        step(0, 0, 0, 64'd0);
        check("br_ifpc", if_pc, 64'h100);
        check("br_valid2", if_valid, 1'b1);

        // PC wraps modulo 2^64
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 64'd0);
        check("wrap_ifpc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_addr", Inst_Address, 64'd0);
        step(0, 0, 0, 64'd0);
        check("wrap_addr2", Inst_Address, 64'd4);

        // Reset during a stall at PC=0x20
        step(0, 0, 1, 64'h20);
        step(0, 1, 0, 64'd0);
        check("pre_rst_addr", Inst_Address, 64'h20);
        step(1, 1, 0, 64'd0);
        check("mid_rst_addr", Inst_Address, 64'd0);
        check("mid_rst_ifpc", if_pc, 64'd0);
        check("mid_rst_inst", if_instruction, 32'd0);
        check("mid_rst_cnt", fetch_count, 32'd0);
        step(0, 0, 0, 64'd0);
        check("mid_boot_valid", if_valid, 1'b0);
        step(0, 0, 0, 64'd0);
        check("restart_ifpc", if_pc, 64'd0);
        check("restart_valid", if_valid, 1'b1);

        // Misaligned redirect halts
        frozen = Inst_Address;
        step(0, 0, 1, 64'h102);
        check("halt_flag", halted, 1'b1);
        check("halt_valid", if_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 64'h200);
            check("halt_addr", Inst_Address, frozen);
            check("halt_hold", halted, 1'b1);
        end
        step(1, 0, 0, 64'd0);
        check("unhalt", halted, 1'b0);
        check("unhalt_addr", Inst_Address, 64'd0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic r, s, b;
            r = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 7))
                0:       tgt = {$urandom, $urandom} | 64'd1;
                1:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                default: tgt = {$urandom, $urandom} & ~64'd3;
            endcase
            step(r, s, b, tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
